// File: rtl/registers.sv
// Eight-entry, 16-bit register file with two combinational read ports and one
// write port that can also byte-swap or set/clear/toggle a bit in place.
module registers (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en,
    input  logic        swap_en,
    input  logic        bit_op_en,
    input  logic [2:0]  read_addr_0,
    input  logic [2:0]  read_addr_1,
    input  logic [2:0]  reg_write_addr,
    input  logic [15:0] data_in,
    input  logic [1:0]  bit_op,
    input  logic [3:0]  bit_position,
    output logic [15:0] read_data_0,
    output logic [15:0] read_data_1
);

    localparam int NUM_REGS = 8;

    logic [15:0] regs_q [NUM_REGS];
    logic [15:0] regs_d [NUM_REGS];
    logic [15:0] cur_val;
    logic [15:0] new_val;

    function automatic logic [15:0] byte_swap(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [15:0] apply_bit_op(
        input logic [15:0] v,
        input logic [1:0]  op,
        input logic [3:0]  pos
    );
        logic [15:0] mask;
        logic [15:0] res;
        mask = 16'h0001 << pos;
        case (op)
            2'b00:   res = v | mask;
            2'b01:   res = v & ~mask;
            2'b10:   res = v ^ mask;
            2'b11:   res = v;
            default: res = v;
        endcase
        return res;
    endfunction

    // Candidate value for the destination register; bit_op/bit_position are
    // only consulted when a bit operation is actually selected.
    always_comb begin
        cur_val = regs_q[reg_write_addr];
        if (bit_op_en) begin
            new_val = apply_bit_op(cur_val, bit_op, bit_position);
        end else if (swap_en) begin
            new_val = byte_swap(cur_val);
        end else begin
            new_val = data_in;
        end
    end

    // Next-state for every entry: only the addressed one changes, and only with write_en.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (write_en && (reg_write_addr == 3'(i))) begin
                regs_d[i] = new_val;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage update; reset overrides any concurrent write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs_q[i] <= 16'h0000;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign read_data_0 = regs_q[read_addr_0];
    assign read_data_1 = regs_q[read_addr_1];

endmodule

// File: tb/tb_registers.sv
// Directed and randomized check of the register file against an arithmetic model.
`timescale 1ns/1ps
module tb_registers;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_en;
    logic        swap_en;
    logic        bit_op_en;
    logic [2:0]  read_addr_0;
    logic [2:0]  read_addr_1;
    logic [2:0]  reg_write_addr;
    logic [15:0] data_in;
    logic [1:0]  bit_op;
    logic [3:0]  bit_position;
    logic [15:0] read_data_0;
    logic [15:0] read_data_1;

    int unsigned model [8];
    int n_checks = 0;
    int n_fail   = 0;

    registers dut (
        .clk            (clk),
        .rst            (rst),
        .write_en       (write_en),
        .swap_en        (swap_en),
        .bit_op_en      (bit_op_en),
        .read_addr_0    (read_addr_0),
        .read_addr_1    (read_addr_1),
        .reg_write_addr (reg_write_addr),
        .data_in        (data_in),
        .bit_op         (bit_op),
        .bit_position   (bit_position),
        .read_data_0    (read_data_0),
        .read_data_1    (read_data_1)
    );

    always #20 clk = ~clk;

    // Bit operation expressed as adding/subtracting the bit weight.
    function automatic int unsigned model_bit(int unsigned v, int op, int pos);
        int unsigned w;
        int unsigned b;
        w = 32'd1 << pos;
        b = (v / w) % 2;
        if (op == 0)      return (b == 0) ? v + w : v;
        else if (op == 1) return (b == 1) ? v - w : v;
        else if (op == 2) return (b == 1) ? v - w : v + w;
        else              return v;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Predict the effect of the current inputs, then cross one rising edge.
    task automatic tick();
        int unsigned nxt [8];
        int unsigned old;
        int a;
        for (int i = 0; i < 8; i++) nxt[i] = model[i];
        a = int'(reg_write_addr);
        old = model[a];
        if (rst) begin
            for (int i = 0; i < 8; i++) nxt[i] = 0;
        end else if (write_en) begin
            if (bit_op_en)    nxt[a] = model_bit(old, int'(bit_op), int'(bit_position));
            else if (swap_en) nxt[a] = (old % 256) * 256 + old / 256;
            else              nxt[a] = int'(data_in);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) model[i] = nxt[i];
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            read_addr_0 = 3'(i);
            read_addr_1 = 3'(7 - i);
            #1;
            check($sformatf("%s_rd0_r%0d", tag, i), read_data_0, 16'(model[i]));
            check($sformatf("%s_rd1_r%0d", tag, 7 - i), read_data_1, 16'(model[7 - i]));
        end
    endtask

    task automatic idle();
        rst = 1'b0; write_en = 1'b0; swap_en = 1'b0; bit_op_en = 1'b0;
        bit_op = 2'b11; bit_position = 4'd0; data_in = 16'h0000; reg_write_addr = 3'd0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        idle(); write_en = 1'b1; reg_write_addr = a; data_in = d; tick();
    endtask

    task automatic do_bit(input logic we, input logic [1:0] op, input logic [3:0] pos);
        idle(); write_en = we; bit_op_en = 1'b1; bit_op = op; bit_position = pos;
        reg_write_addr = 3'd0; data_in = 16'h5A5A; tick();
    endtask

    initial begin
        idle();
        read_addr_0 = 3'd0;
        read_addr_1 = 3'd0;
        for (int i = 0; i < 8; i++) model[i] = 0;

        // Reset wins over a concurrent write
        rst = 1'b1; write_en = 1'b1; reg_write_addr = 3'd3; data_in = 16'hFFFF;
        tick();
        tick();
        idle();
        check_all("reset");

        // Plain writes
        do_write(3'd2, 16'h1234);
        do_write(3'd5, 16'h5678);
        read_addr_0 = 3'd2; read_addr_1 = 3'd5; #1;
        check("wr_r2", read_data_0, 16'h1234);
        check("wr_r5", read_data_1, 16'h5678);

        // Byte swap ignores data_in; second swap restores
        idle(); write_en = 1'b1; swap_en = 1'b1; reg_write_addr = 3'd2; data_in = 16'hFFFF;
        tick();
        read_addr_0 = 3'd2; #1;
        check("swap1", read_data_0, 16'h3412);
        tick();
        check("swap2", read_data_0, 16'h1234);
        tick();
        check("swap3", read_data_0, 16'h3412);

        // Simultaneous read and write: old value until the edge
        idle(); write_en = 1'b1; reg_write_addr = 3'd2; data_in = 16'h2345;
        read_addr_0 = 3'd2; read_addr_1 = 3'd0; #1;
        check("rw_before", read_data_0, 16'h3412);
        check("rw_r0_before", read_data_1, 16'h0000);
        tick();
        check("rw_after", read_data_0, 16'h2345);
        check("rw_r0_after", read_data_1, 16'h0000);

        // Bit operations on r0
        read_addr_0 = 3'd0;
        do_bit(1'b1, 2'b00, 4'd15); check("bit_set15", read_data_0, 16'h8000);
        do_bit(1'b1, 2'b10, 4'd0);  check("bit_tgl0",  read_data_0, 16'h8001);
        do_bit(1'b1, 2'b01, 4'd15); check("bit_clr15", read_data_0, 16'h0001);
        do_bit(1'b1, 2'b11, 4'd0);  check("bit_hold",  read_data_0, 16'h0001);
        do_bit(1'b0, 2'b00, 4'd7);  check("bit_no_we", read_data_0, 16'h0001);

        // Bit op has priority over swap
        idle(); write_en = 1'b1; bit_op_en = 1'b1; swap_en = 1'b1;
        bit_op = 2'b00; bit_position = 4'd4; reg_write_addr = 3'd0; data_in = 16'hAAAA;
        tick();
        check("prio_bit_over_swap", read_data_0, 16'h0011);

        // No write without write_en
        idle(); swap_en = 1'b1; data_in = 16'hAAAA; reg_write_addr = 3'd5;
        tick();
        check_all("no_we");

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            rst            = ($urandom_range(0, 29) == 0);
            write_en       = 1'($urandom);
            swap_en        = 1'($urandom);
            bit_op_en      = ($urandom_range(0, 2) == 0);
            bit_op         = 2'($urandom);
            bit_position   = 4'($urandom);
            reg_write_addr = 3'($urandom);
            data_in        = 16'($urandom);
            read_addr_0    = 3'($urandom);
            read_addr_1    = reg_write_addr;
            #1;
            check("rnd_pre_rd0", read_data_0, 16'(model[read_addr_0]));
            check("rnd_pre_rd1", read_data_1, 16'(model[read_addr_1]));
            tick();
            check("rnd_post_rd0", read_data_0, 16'(model[read_addr_0]));
            check("rnd_post_rd1", read_data_1, 16'(model[read_addr_1]));
            if (it % 25 == 24) check_all("rnd_all");
        end

        // Reset mid-operation
        idle(); do_write(3'd5, 16'h1111);
        idle(); rst = 1'b1; write_en = 1'b1; reg_write_addr = 3'd5; data_in = 16'hBEEF;
        tick();
        idle();
        read_addr_0 = 3'd5; #1;
        check("midrst_r5", read_data_0, 16'h0000);
        check_all("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
